// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and RAM control constants shared by the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} arb_state_t;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic [2:0] MS_BYTE  = 3'b000;
    localparam logic [2:0] MS_HALF  = 3'b001;
    localparam logic [2:0] MS_WORD  = 3'b010;
    localparam logic [2:0] MS_DWORD = 3'b011;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: ACCESS-cycle counter that flags expiry on the CYCLES-th enabled cycle.
module mem_arb_timer #(
    parameter int CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    assign expired = enable && (cnt == W'(CYCLES - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter and MOV/MOC sequencer for the RAM port.
// Optional ACCESS timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              RW0,
    input  logic              RW1,
    input  logic [2:0]        MS0,
    input  logic [2:0]        MS1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [DATA_W-1:0] RDATA0,
    output logic [DATA_W-1:0] RDATA1,
    output logic              ERR,
    output logic [1:0]        GRANT,
    output logic              MOV,
    output logic              MEM_RW,
    output logic [2:0]        MEM_MS,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic              MOC,
    input  logic [DATA_W-1:0] MEM_DOUT
);
    arb_state_t state, state_nxt;
    logic last, err_q, pick1, start, finish, timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (state != ACCESS),
        .enable  (state == ACCESS),
        .expired (timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // last = 1 means requester 1 owned the previous grant, so requester 0 wins a tie
    assign pick1  = REQ1 && (!REQ0 || !last);
    assign start  = (state == IDLE) && (REQ0 || REQ1);
    assign finish = (state == ACCESS) && (MOC || timeout);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ACCESS : IDLE;
            ACCESS:  state_nxt = finish ? DONE : ACCESS;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            last     <= 1'b1;
            err_q    <= 1'b0;
            GRANT    <= 2'b00;
            MEM_RW   <= 1'b0;
            MEM_MS   <= '0;
            MEM_ADDR <= '0;
            MEM_DIN  <= '0;
            RDATA0   <= '0;
            RDATA1   <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                GRANT    <= pick1 ? 2'b10 : 2'b01;
                last     <= pick1;
                err_q    <= 1'b0;
                MEM_RW   <= pick1 ? RW1 : RW0;
                MEM_MS   <= pick1 ? MS1 : MS0;
                MEM_ADDR <= pick1 ? ADDR1 : ADDR0;
                MEM_DIN  <= pick1 ? WDATA1 : WDATA0;
            end
            // MOC arriving on the timeout edge counts as a normal completion
            if (finish) begin
                err_q <= !MOC;
                if (MEM_RW == READ && GRANT[0]) RDATA0 <= MOC ? MEM_DOUT : '0;
                if (MEM_RW == READ && GRANT[1]) RDATA1 <= MOC ? MEM_DOUT : '0;
            end
            if (state == DONE) GRANT <= 2'b00;
        end
    end

    assign MOV  = (state == ACCESS);
    assign ACK0 = (state == DONE) && GRANT[0];
    assign ACK1 = (state == DONE) && GRANT[1];
    assign ERR  = (state == DONE) && err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transaction-level checks of mem_port_arbiter.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    localparam int TCYC = 4;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, REQ1, RW0, RW1, MOC;
    logic [2:0]  MS0, MS1, MEM_MS;
    logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1, MEM_DOUT;
    logic        ACK0, ACK1, ERR, MOV, MEM_RW;
    logic [1:0]  GRANT;
    logic [31:0] RDATA0, RDATA1, MEM_ADDR, MEM_DIN;
    int passes = 0, fails = 0, total = 0;
    bit exp_last;
    logic [31:0] exp_rd [2];

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TCYC)) dut (
        .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .RW0(RW0), .RW1(RW1),
        .MS0(MS0), .MS1(MS1), .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1), .ERR(ERR), .GRANT(GRANT),
        .MOV(MOV), .MEM_RW(MEM_RW), .MEM_MS(MEM_MS), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MOC(MOC), .MEM_DOUT(MEM_DOUT)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction from IDLE; MOC arrives in ACCESS cycle lat, or never when moc_on = 0.
    task automatic do_txn(input bit r0, input bit r1, input bit rw0_i, input bit rw1_i,
                          input logic [2:0] ms0_i, input logic [2:0] ms1_i,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] dout, input int lat, input bit moc_on);
        bit w, erw;
        int n;
        logic [31:0] ea, ed;
        logic [2:0] ems;
        logic [1:0] eg;
        REQ0 = r0; REQ1 = r1; RW0 = rw0_i; RW1 = rw1_i; MS0 = ms0_i; MS1 = ms1_i;
        ADDR0 = a0; ADDR1 = a1; WDATA0 = d0; WDATA1 = d1;
        w = (r0 && r1) ? !exp_last : r1;
        exp_last = w;
        eg  = w ? 2'b10 : 2'b01;
        ea  = w ? a1 : a0;
        ed  = w ? d1 : d0;
        ems = w ? ms1_i : ms0_i;
        erw = w ? rw1_i : rw0_i;
        n = moc_on ? lat : TCYC;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            chk("access_mov", MOV, 1);
            chk("access_grant", GRANT, eg);
            chk("access_ack", {ACK1, ACK0}, 0);
            chk("access_addr", MEM_ADDR, ea);
            chk("access_din", MEM_DIN, ed);
            chk("access_ms", MEM_MS, ems);
            chk("access_rw", MEM_RW, erw);
            ADDR0 = $urandom; ADDR1 = $urandom; WDATA0 = $urandom; WDATA1 = $urandom;
            MS0 = 3'($urandom); MS1 = 3'($urandom); RW0 = 1'($urandom); RW1 = 1'($urandom);
            MOC = moc_on && (k == lat);
            MEM_DOUT = (k == n) ? dout : $urandom;
        end
        @(negedge CLK);
        MOC = 1'b0;
        if (erw == READ) exp_rd[w] = moc_on ? dout : 32'h0;
        chk("done_mov", MOV, 0);
        chk("done_ack", {ACK1, ACK0}, eg);
        chk("done_err", ERR, !moc_on);
        chk("done_grant", GRANT, eg);
        chk("rdata0", RDATA0, exp_rd[0]);
        chk("rdata1", RDATA1, exp_rd[1]);
        if (w) REQ1 = 1'b0; else REQ0 = 1'b0;
        @(negedge CLK);
        chk("idle_quiet", {GRANT, ACK1, ACK0, MOV}, 0);
    endtask

    initial begin
        logic [1:0] r;
        RESET = 1'b1; REQ0 = 0; REQ1 = 0; RW0 = 0; RW1 = 0; MS0 = 0; MS1 = 0; MOC = 0;
        ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0; MEM_DOUT = 0;
        exp_last = 1'b1; exp_rd[0] = 0; exp_rd[1] = 0;
        repeat (2) @(negedge CLK);
        chk("rst_outputs", {MOV, GRANT, ACK0, ACK1, ERR, MEM_RW, MEM_MS}, 0);
        chk("rst_mem", {MEM_ADDR, MEM_DIN}, 0);
        chk("rst_rdata", {RDATA0, RDATA1}, 0);
        RESET = 1'b0;

        // contention out of reset: strict 0,1,0,1
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, WRITE, WRITE, MS_WORD, MS_BYTE, 32'h100 + i, 32'h200 + i,
                   $urandom, $urandom, $urandom, i + 1, 1);

        // single read
        do_txn(1, 0, READ, WRITE, MS_WORD, MS_WORD, 32'h10, 0, 0, 0, 32'hE1A0_0000, 2, 1);
        chk("single_read_rdata0", RDATA0, 32'hE1A0_0000);

        // write pass-through on requester 1
        do_txn(0, 1, READ, WRITE, MS_WORD, 3'b010, 0, 32'h20, 0, 32'hDEAD_BEEF, $urandom, 3, 1);

        // spurious MOC while idle
        MOC = 1'b1; MEM_DOUT = 32'h1234_5678;
        repeat (2) begin
            @(negedge CLK);
            chk("spurious_moc", {GRANT, ACK1, ACK0, MOV, ERR}, 0);
            chk("spurious_rdata", {RDATA0, RDATA1}, {exp_rd[0], exp_rd[1]});
        end
        MOC = 1'b0;

        // reset in the middle of ACCESS
        REQ0 = 1; RW0 = READ; ADDR0 = 32'h44; REQ1 = 0;
        @(negedge CLK);
        chk("pre_rst_mov", MOV, 1);
        #2 RESET = 1'b1;
        #1 chk("rst_async_mov", MOV, 0);
        chk("rst_async_quiet", {GRANT, ACK1, ACK0}, 0);
        REQ0 = 0;
        @(negedge CLK);
        RESET = 1'b0;
        exp_last = 1'b1; exp_rd[0] = 0; exp_rd[1] = 0;
        @(negedge CLK);
        chk("post_rst_quiet", {MOV, GRANT, ACK1, ACK0, RDATA0}, 0);
        do_txn(1, 0, READ, READ, MS_WORD, MS_WORD, 32'h48, 0, 0, 0, 32'hCAFE_0001, 1, 1);

`ifdef MEM_ARB_TIMEOUT_EN
        do_txn(1, 0, READ, READ, MS_WORD, MS_WORD, 32'h50, 0, 0, 0, 32'h5555_AAAA, 0, 0);
        chk("timeout_rdata0", RDATA0, 0);
        do_txn(1, 0, READ, READ, MS_WORD, MS_WORD, 32'h54, 0, 0, 0, 32'h0BAD_F00D, TCYC, 1);
        chk("moc_at_timeout_rdata0", RDATA0, 32'h0BAD_F00D);
`endif

        // randomized transactions with random idle gaps and stray MOC
        for (int t = 0; t < 40; t++) begin
            r = 2'($urandom_range(1, 3));
            do_txn(r[0], r[1], 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 4), 1);
            if ($urandom_range(0, 1) == 1) begin
                REQ0 = 0; REQ1 = 0; MOC = 1'($urandom);
                repeat ($urandom_range(1, 2)) begin
                    @(negedge CLK);
                    chk("gap_quiet", {GRANT, ACK1, ACK0, MOV}, 0);
                end
                MOC = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single `ram256x8` port. It shares the memory between the control-unit data path (requester 0) and a secondary master such as a loader or debug port (requester 1). It latches the granted request, drives the MOV/MOC handshake, returns read data, and acknowledges the requester. It sits between the requesters and the RAM's MOV, R/W, MS, address, data-in, MOC and data-out pins.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT_CYCLES`, default 16: cycles in ACCESS without MOC before abort; only used with `MEM_ARB_TIMEOUT_EN`.

Ports:
- Clock and reset: one clock, `CLK`; reset is `RESET`, asynchronous and active-high.
- `CLK` in 1: rising-edge clock.
- `RESET` in 1: async active-high reset.
- `REQ0`, `REQ1` in 1: request, held high until ACK.
- `RW0`, `RW1` in 1: 1 = read, 0 = write.
- `MS0`, `MS1` in 3: size code, passed to RAM unmodified.
- `ADDR0`, `ADDR1` in ADDR_W: request address.
- `WDATA0`, `WDATA1` in DATA_W: write data.
- `ACK0`, `ACK1` out 1: one-cycle completion pulse.
- `RDATA0`, `RDATA1` out DATA_W: read data, valid with ACK, held until the next grant to the same requester.
- `ERR` out 1: timeout pulse, coincident with ACK.
- `GRANT` out 2: one-hot owner of the current transaction; 00 when idle.
- `MOV` out 1: memory operation valid.
- `MEM_RW` out 1: to RAM R/W.
- `MEM_MS` out 3: to RAM MS.
- `MEM_ADDR` out ADDR_W: to RAM address (MAR side).
- `MEM_DIN` out DATA_W: to RAM data-in (MDR side).
- `MOC` in 1: memory operation complete.
- `MEM_DOUT` in DATA_W: RAM data-out.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - Sample REQ0 and REQ1.
  - If neither is high, stay.
  - If one is high, grant it.
  - If both are high, grant the requester that is not `LAST`.
  - On grant: latch RW, MS, ADDR and WDATA into the MEM_* registers, set GRANT, update `LAST`, go to ACCESS.
- **ACCESS**
  - MOV = 1; MEM_* outputs stable.
  - On MOC sampled high:
    - On a read, capture MEM_DOUT into the granted RDATA.
    - Go to DONE.
- **DONE**
  - MOV = 0.
  - The granted ACK is high for exactly this cycle.
  - Next state is always IDLE. This guarantees at least one MOV-low cycle between transactions.
- Requester rules:
  - The requester must drop REQ in the cycle after ACK.
  - A REQ still high when IDLE samples it is a new request.
  - Request fields may change freely after grant, because they are latched.
- Boundary conditions:
  - MOC outside ACCESS is ignored.
  - A REQ that rises during ACCESS or DONE waits for IDLE.
  - Writes leave RDATA unchanged.
- Reset:
  - MOV, MEM_*, GRANT, ACK, ERR, RDATA and the timer are cleared to 0; state = IDLE; `LAST` = 1 (requester 0 wins the first tie).
  - Reset mid-transaction abandons it: MOV drops asynchronously and no ACK is issued.

## Timing
- REQ high before edge E: grant and MOV = 1 after edge E.
- MOC sampled high at edge E+n (n ≥ 1): ACK high from E+n to E+n+1; MOV low after E+n.
- Minimum request-to-ACK is 2 edges (n = 1).
- Minimum back-to-back period per transaction is 3 cycles (ACCESS, DONE, IDLE).
- Under continuous contention, grants alternate strictly 0, 1, 0, 1.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES without MOC: go to DONE, pulse ACK and ERR together, clear the granted RDATA to 0 (reads only).
  - MOC on the same edge as timeout wins: normal completion, ERR = 0.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter; ACCESS waits indefinitely; ERR tied to 0.

## Structure
- Package `mem_arb_pkg`:
  - State encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2).
  - RW constants: READ = 1, WRITE = 0.
  - MS size-code constants shared with the RAM and SLS manager.
- Sub-module `mem_arb_timer`:
  - Counter with `clear`, `enable` and `expired`.
  - Instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- **Single read.** REQ0 read, ADDR0 = 0x10; RAM replies with MOC after 2 cycles, MEM_DOUT = 0xE1A0_0000.
  - Expect MOV high for 2 cycles, ACK0 one pulse, RDATA0 = 0xE1A0_0000, GRANT = 01 then 00.
- **Contention.** REQ0 and REQ1 rise together out of reset, both writes.
  - Expect requester 0 granted first, then requester 1.
  - Holding both requests high for 4 transactions gives grant order 0, 1, 0, 1.
- **Write pass-through.** REQ1 write, ADDR1 = 0x20, WDATA1 = 0xDEAD_BEEF, MS1 = 3'b010.
  - Expect MEM_ADDR = 0x20, MEM_DIN = 0xDEAD_BEEF, MEM_MS = 3'b010, MEM_RW = 0 throughout ACCESS; RDATA1 unchanged.
- **Reset mid-operation.** Assert RESET during ACCESS.
  - Expect MOV = 0 immediately with no clock edge, no ACK, state IDLE.
  - After release, a new REQ0 completes normally.
- **Timeout (macro on, TIMEOUT_CYCLES = 4).** Read with MOC never asserted.
  - Expect ACK0 and ERR pulsed on the 4th ACCESS cycle, RDATA0 = 0.
  - Repeat with MOC on exactly the 4th cycle: expect ERR = 0 and data captured.
- **Spurious MOC.** Pulse MOC while IDLE.
  - Expect no ACK, no state change.
